// File: rtl/tpu_pkg.sv
// Shared types for the TPU fetch path: fetch FSM states, the HALT encoding
// and the layout of a queued instruction entry at the default widths.
package tpu_pkg;

    localparam int DEF_BITNESS    = 32;
    localparam int DEF_ADDR_WIDTH = 16;

    // An all-ones instruction word stops the fetch stage after it is queued.
    localparam logic [DEF_BITNESS-1:0] HALT_WORD = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_BITNESS-1:0]    data;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO holding fetched {data, addr} entries.
// Head is presented combinationally and forced to zero while empty so the
// downstream outputs read as zero out of reset.
module instr_queue #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign pop_valid = (count != '0);
    assign do_pop    = pop && pop_valid;
    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_push   = push && ((count != FULL) || do_pop);
    assign pop_data  = pop_valid ? slots[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Entry storage; contents are only observable through a valid head, so no reset.
    always_ff @(posedge clock) begin
        if (do_push && !flush)
            slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the control unit: one outstanding program
// memory read at a time, responses buffered in instr_queue, head handed to
// the control unit over valid/ready together with its word address.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | not fetching; start loads the PC and issues the first request
//  RUN   | fetching; a request issues when nothing is in flight and the
//        | queue has a free slot for its response
//  STOP  | HALT word queued; no new requests, back to IDLE once drained
module instr_fetch
    import tpu_pkg::*;
#(
    parameter int BITNESS     = DEF_BITNESS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [BITNESS-1:0]    mem_rdata,
    output logic                  instr_valid,
    output logic [BITNESS-1:0]    instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_ready,
    output logic                  busy
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int EW = BITNESS + ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    fetch_state_t          state;
    fetch_state_t          state_d;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  outstanding;
    logic                  discard;
    logic                  issue;
    logic                  granted;
    logic                  push;
    logic                  pop;
    logic                  is_halt;
    logic [CW-1:0]         count;
    logic [EW-1:0]         push_entry;
    logic [EW-1:0]         head_entry;

    assign granted    = mem_req && mem_gnt;
    // Responses are dropped while a redirect is pending or arrives this cycle.
    assign push       = mem_rvalid && !discard && !flush;
    assign is_halt    = &mem_rdata;
    assign pop        = instr_valid && instr_ready;
    assign push_entry = {mem_rdata, req_addr};

    assign mem_addr   = pc;
    assign instr_data = head_entry[EW-1:ADDR_WIDTH];
    assign instr_addr = head_entry[ADDR_WIDTH-1:0];
    assign busy       = (state != IDLE) || instr_valid;

    // Next-state and request-issue decision; flush overrides everything.
    always_comb begin
        state_d = state;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                // Waiting for outstanding to clear also covers the rvalid cycle,
                // which guarantees a slot exists when the response lands.
                issue = !mem_req && !outstanding && (count < DEPTH_C);
                if (push && is_halt)
                    state_d = STOP;
            end
            STOP: begin
                if ((count == '0) && !outstanding)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = RUN;
            issue   = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // PC, request handshake and in-flight tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            req_addr    <= '0;
            mem_req     <= 1'b0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else begin
            if (granted) begin
                req_addr <= pc;
                pc       <= pc + ADDR_WIDTH'(1);
            end
            if ((state == IDLE) && start)
                pc <= start_addr;
            if (flush)
                pc <= flush_addr;

            // A held request keeps its address until granted; a redirect withdraws
            // it and the next request goes out from flush_addr a cycle later.
            if (flush)
                mem_req <= 1'b0;
            else if (mem_req)
                mem_req <= !mem_gnt;
            else
                mem_req <= issue;

            if (granted)
                outstanding <= 1'b1;
            else if (mem_rvalid)
                outstanding <= 1'b0;

            // The read still in flight after a redirect belongs to the old stream.
            if (flush)
                discard <= granted || (outstanding && !mem_rvalid);
            else if (mem_rvalid)
                discard <= 1'b0;
        end
    end

    instr_queue #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .pop_valid (instr_valid),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory responder, expected instruction
// stream computed from start address, address wrap and HALT position.
module tb_instr_fetch;
    import tpu_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] start_addr;
    logic        flush;
    logic [15:0] flush_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [15:0] instr_addr;
    logic        instr_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [15:0] halt_addr = 16'hBEEF;

    fetch_entry_t obs_q[$];
    logic [15:0]  req_q[$];
    fetch_entry_t mon_e;
    logic [66:0]  outs;

    assign outs = {mem_req, mem_addr, instr_valid, instr_data, instr_addr, busy};

    instr_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program image: HALT at halt_addr, otherwise a word that can never be all ones.
    function automatic logic [31:0] pmem(input logic [15:0] a);
        if (a == halt_addr) return HALT_WORD;
        return {8'h3C, a, 8'hC3};
    endfunction

    task automatic cycle();
        @(posedge clock);
        #2;
    endtask

    // Memory model: random grant, random read latency, forgets its read on reset.
    initial begin : responder
        int unsigned timer;
        logic        inflight;
        logic [15:0] raddr;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        timer = 0; inflight = 1'b0; raddr = '0;
        forever begin
            @(negedge clock);
            if (reset && mem_req && mem_gnt) begin
                raddr    = mem_addr;
                timer    = $urandom_range(lat_max, lat_min);
                inflight = 1'b1;
            end
            @(posedge clock);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (!reset) begin
                inflight = 1'b0;
            end else if (inflight) begin
                timer = timer - 1;
                if (timer == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pmem(raddr);
                    inflight   = 1'b0;
                end
            end
            mem_gnt = mem_req && ($urandom_range(99, 0) < gnt_pct);
        end
    end

    // Transaction log of deliveries to cu and of granted request addresses.
    always @(negedge clock) begin
        if (reset && instr_valid && instr_ready) begin
            mon_e.data = instr_data;
            mon_e.addr = instr_addr;
            obs_q.push_back(mon_e);
        end
        if (reset && mem_req && mem_gnt)
            req_q.push_back(mem_addr);
    end

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; start_addr = '0; flush = 1'b0; flush_addr = '0;
        instr_ready = 1'b0;
        repeat (3) cycle();
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
        reset = 1'b1;
        repeat (2) cycle();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", mem_req); end
    endtask

    task automatic test_basic();
        int n;
        halt_addr = 16'h0013; gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1'b1;
        obs_q.delete(); req_q.delete();
        start = 1'b1; start_addr = 16'h0010;
        cycle();
        start = 1'b0;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_rise: got %0b want 1", mem_req); end
        n_tests++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL basic_req_addr: got %h want 0010", mem_addr); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
        cycle();
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %0b want 0", instr_valid); end
        cycle();
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", instr_valid); end
        n_tests++; if (instr_addr !== 16'h0010) begin n_fail++; $display("FAIL basic_first_addr: got %h want 0010", instr_addr); end
        n_tests++; if (instr_data !== pmem(16'h0010)) begin n_fail++; $display("FAIL basic_first_data: got %h want %h", instr_data, pmem(16'h0010)); end
        n = 0;
        while (obs_q.size() < 3 && n < 100) begin cycle(); n++; end
        n_tests++; if (n >= 100) begin n_fail++; $display("FAIL basic_timeout: got %0d words want 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i].addr !== 16'h0010 + 16'(i) || obs_q[i].data !== pmem(16'h0010 + 16'(i))) begin
                n_fail++; $display("FAIL basic_word%0d: got %h/%h want %h", i, obs_q[i].addr, obs_q[i].data, 16'h0010 + 16'(i));
            end
        end
    endtask

    task automatic test_halt();
        int n;
        n = 0;
        while (busy && n < 200) begin cycle(); n++; end
        n_tests++; if (n >= 200) begin n_fail++; $display("FAIL halt_busy_fall: got %0b want 0", busy); end
        repeat (10) cycle();
        n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL halt_count: got %0d words want 4", obs_q.size()); end
        if (obs_q.size() == 4) begin
            n_tests++;
            if (obs_q[3].addr !== 16'h0013 || obs_q[3].data !== HALT_WORD) begin
                n_fail++; $display("FAIL halt_word: got %h/%h want 0013/%h", obs_q[3].addr, obs_q[3].data, HALT_WORD);
            end
        end
        n_tests++; if (req_q.size() != 4) begin n_fail++; $display("FAIL halt_no_0014: got %0d requests want 4", req_q.size()); end
        n_tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL halt_quiet: got req=%0b busy=%0b want 0 0", mem_req, busy); end
    endtask

    task automatic test_wrap();
        int n;
        int exp_len;
        logic [15:0] s;
        s = 16'hFFFF; halt_addr = 16'h0001; gnt_pct = 50; lat_min = 1; lat_max = 3;
        obs_q.delete(); req_q.delete();
        start = 1'b1; start_addr = s;
        cycle();
        start = 1'b0;
        n = 0;
        while (busy && n < 500) begin
            instr_ready = ($urandom_range(3, 0) != 0);
            cycle(); n++;
        end
        instr_ready = 1'b1;
        n_tests++; if (n >= 500) begin n_fail++; $display("FAIL wrap_timeout: busy %0b want 0", busy); end
        n_tests++; if (req_q.size() < 2 || req_q[1] !== 16'h0000) begin n_fail++; $display("FAIL wrap_second_req: got %0d reqs want second 0000", req_q.size()); end
        exp_len = int'(16'(halt_addr - s)) + 1;
        n_tests++; if (obs_q.size() != exp_len) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_len); end
        for (int i = 0; i < obs_q.size() && i < exp_len; i++) begin
            n_tests++;
            if (obs_q[i].addr !== s + 16'(i) || obs_q[i].data !== pmem(s + 16'(i))) begin
                n_fail++; $display("FAIL wrap_word%0d: got %h/%h want %h", i, obs_q[i].addr, obs_q[i].data, s + 16'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic stable_bad;
        halt_addr = 16'hBEEF; gnt_pct = 60; lat_min = 1; lat_max = 3; instr_ready = 1'b0;
        obs_q.delete(); req_q.delete();
        start = 1'b1; start_addr = 16'h0100;
        cycle();
        start = 1'b0;
        stable_bad = 1'b0;
        for (int k = 0; k < 80; k++) begin
            start = (k == 40); start_addr = 16'h0999;
            cycle();
            if (instr_valid && (instr_addr !== 16'h0100 || instr_data !== pmem(16'h0100))) stable_bad = 1'b1;
        end
        start = 1'b0;
        n_tests++; if (stable_bad) begin n_fail++; $display("FAIL bp_head_stable: head changed while stalled, want 0100"); end
        n_tests++; if (req_q.size() != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", req_q.size()); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_idle: got %0b want 0", mem_req); end
        n_tests++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0100) begin n_fail++; $display("FAIL bp_head: got %0b/%h want 1/0100", instr_valid, instr_addr); end
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        repeat (40) cycle();
        n_tests++; if (req_q.size() != 5 || req_q[req_q.size()-1] !== 16'h0104) begin n_fail++; $display("FAIL bp_one_refill: got %0d reqs want 5 ending 0104", req_q.size()); end
        n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL bp_one_pop: got %0d words want 1", obs_q.size()); end
        for (int k = 0; k < 300; k++) begin
            instr_ready = 1'($urandom_range(1, 0));
            cycle();
        end
        n_tests++; if (obs_q.size() < 20) begin n_fail++; $display("FAIL bp_progress: got %0d words want >=20", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i].addr !== 16'h0100 + 16'(i) || obs_q[i].data !== pmem(16'h0100 + 16'(i))) begin
                n_fail++; $display("FAIL bp_order%0d: got %h/%h want %h", i, obs_q[i].addr, obs_q[i].data, 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_flush();
        int n;
        // Redirect while a granted read is still unanswered.
        gnt_pct = 100; lat_min = 3; lat_max = 3; instr_ready = 1'b1;
        n = 0;
        while (!mem_req && n < 60) begin cycle(); n++; end
        n_tests++; if (n >= 60) begin n_fail++; $display("FAIL flushA_wait: mem_req %0b want 1", mem_req); end
        cycle();
        flush = 1'b1; flush_addr = 16'h0040;
        cycle();
        flush = 1'b0;
        obs_q.delete(); req_q.delete();
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flushA_valid: got %0b want 0", instr_valid); end
        n = 0;
        while (obs_q.size() < 1 && n < 60) begin cycle(); n++; end
        n_tests++;
        if (obs_q.size() < 1 || obs_q[0].addr !== 16'h0040 || obs_q[0].data !== pmem(16'h0040)) begin
            n_fail++; $display("FAIL flushA_first: got %0d words want first 0040", obs_q.size());
        end

        // Redirect in the same cycle the pending request is granted.
        lat_min = 2; lat_max = 2;
        n = 0;
        while (!(mem_req && mem_gnt) && n < 60) begin cycle(); n++; end
        flush = 1'b1; flush_addr = 16'h0080;
        cycle();
        flush = 1'b0;
        obs_q.delete(); req_q.delete();
        n = 0;
        while (obs_q.size() < 1 && n < 60) begin cycle(); n++; end
        n_tests++;
        if (obs_q.size() < 1 || obs_q[0].addr !== 16'h0080 || obs_q[0].data !== pmem(16'h0080)) begin
            n_fail++; $display("FAIL flushB_first: got %0d words want first 0080", obs_q.size());
        end

        // Redirect while the request is still waiting for a grant.
        gnt_pct = 0;
        n = 0;
        while (!(mem_req && !mem_gnt) && n < 60) begin cycle(); n++; end
        flush = 1'b1; flush_addr = 16'h00C0;
        cycle();
        flush = 1'b0;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flushC_drop: got %0b want 0", mem_req); end
        gnt_pct = 100;
        obs_q.delete(); req_q.delete();
        n = 0;
        while (obs_q.size() < 1 && n < 60) begin cycle(); n++; end
        n_tests++; if (req_q.size() < 1 || req_q[0] !== 16'h00C0) begin n_fail++; $display("FAIL flushC_reissue: got %0d reqs want first 00C0", req_q.size()); end
        n_tests++;
        if (obs_q.size() < 1 || obs_q[0].addr !== 16'h00C0) begin
            n_fail++; $display("FAIL flushC_first: got %0d words want first 00C0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int exp_len;
        logic [15:0] s;
        gnt_pct = 100; lat_min = 3; lat_max = 3; instr_ready = 1'b0;
        flush = 1'b1; flush_addr = 16'h0200;
        cycle();
        flush = 1'b0;
        obs_q.delete(); req_q.delete();
        n = 0;
        while (req_q.size() < 3 && n < 80) begin cycle(); n++; end
        n_tests++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0200) begin n_fail++; $display("FAIL rstmid_pre: got %0b/%h want 1/0200", instr_valid, instr_addr); end
        reset = 1'b0;
        #1;
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        n_tests++; if (busy !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%0b req=%0b want 0 0", busy, mem_req); end
        s = 16'h0300; halt_addr = 16'h0302; gnt_pct = 70; lat_min = 1; lat_max = 2; instr_ready = 1'b1;
        obs_q.delete(); req_q.delete();
        start = 1'b1; start_addr = s;
        cycle();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin cycle(); n++; end
        n_tests++; if (n >= 200) begin n_fail++; $display("FAIL rstmid_timeout: busy %0b want 0", busy); end
        exp_len = int'(16'(halt_addr - s)) + 1;
        n_tests++; if (obs_q.size() != exp_len) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_len); end
        for (int i = 0; i < obs_q.size() && i < exp_len; i++) begin
            n_tests++;
            if (obs_q[i].addr !== s + 16'(i) || obs_q[i].data !== pmem(s + 16'(i))) begin
                n_fail++; $display("FAIL rstmid_word%0d: got %h/%h want %h", i, obs_q[i].addr, obs_q[i].data, s + 16'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_wrap();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
